// File: rtl/lcd_bus_master.sv
// lcd_bus_master: turns byte write requests into nCS/nWR/nRD/RS/DB bus cycles
// for the LCD timing controller. It can optionally poll the HD44780 busy flag
// (RS=0 read, DB7) before each write, and it gives up after POLL_LIMIT busy reads.
// Every bus output is a flop decoded from the next state, so strobes never glitch.
module lcd_bus_master #(
  parameter int WR_HOLD    = 20,
  parameter int RD_HOLD    = 8,
  parameter int RD_SAMPLE  = 4,
  parameter int GAP        = 4,
  parameter int POLL_LIMIT = 1023
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  input  logic       poll_en,
  output logic       done,
  output logic       busy_to,
  output logic [7:0] last_status,
  output logic       nCS,
  output logic       nWR,
  output logic       nRD,
  output logic       RS,
  output logic [7:0] DB_out,
  output logic       DB_oe,
  input  logic [7:0] DB_in
);

  localparam int CNT_W = $clog2(WR_HOLD + RD_HOLD + GAP + 1);
  localparam int PC_W  = $clog2(POLL_LIMIT + 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_STB,
    RD_GAP,
    SETUP,
    WR_STB,
    HOLD,
    WR_GAP
  } state_t;

  state_t           state;
  state_t           nextState;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntNext;
  logic [PC_W-1:0]  pollCnt;
  logic [PC_W-1:0]  pollNext;
  logic             rsLat;
  logic [7:0]       dataLat;

  logic             accept;
  logic             drive;
  logic             rsSel;
  logic [7:0]       dataSel;
  logic [7:0]       statusNext;
  logic             abortNext;
  logic             doneNext;
  logic             busyToNext;
  logic             pollExhausted;

  // Next-state, counter, poll count and the next values of the registered outputs
  always_comb begin
    accept        = req_valid & req_ready;
    nextState     = state;
    cntNext       = cnt + CNT_W'(1);
    pollNext      = pollCnt;
    statusNext    = last_status;
    pollExhausted = (int'(pollCnt) + 1) >= POLL_LIMIT;

    case (state)
      IDLE: begin
        if (accept) begin
          pollNext  = '0;
          nextState = poll_en ? RD_STB : SETUP;
        end
      end
      RD_STB: begin
        if (cnt == CNT_W'(RD_SAMPLE)) begin
          statusNext = DB_in;
        end
        if (cnt == CNT_W'(RD_HOLD - 1)) begin
          nextState = RD_GAP;
        end
      end
      RD_GAP: begin
        if (cnt == CNT_W'(GAP - 1)) begin
          if (!last_status[7]) begin
            nextState = SETUP;
          end else if (!pollExhausted) begin
            pollNext  = pollCnt + PC_W'(1);
            nextState = RD_STB;
          end else begin
            nextState = IDLE;
          end
        end
      end
      SETUP: begin
        nextState = WR_STB;
      end
      WR_STB: begin
        if (cnt == CNT_W'(WR_HOLD - 1)) begin
          nextState = HOLD;
        end
      end
      HOLD: begin
        nextState = WR_GAP;
      end
      WR_GAP: begin
        if (cnt == CNT_W'(GAP - 1)) begin
          nextState = IDLE;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase

    if (nextState != state) begin
      cntNext = '0;
    end

    // done and the timeout flag land in the last gap cycle, not after it
    abortNext = (nextState == RD_GAP) && (cntNext == CNT_W'(GAP - 1)) &&
                statusNext[7] && pollExhausted;
    doneNext  = abortNext ||
                ((nextState == WR_GAP) && (cntNext == CNT_W'(GAP - 1)));

    busyToNext = busy_to;
    if (accept) begin
      busyToNext = 1'b0;
    end else if (abortNext) begin
      busyToNext = 1'b1;
    end

    // The accept edge loads SETUP, so the request fields bypass the latches then
    rsSel   = (state == IDLE) ? req_rs   : rsLat;
    dataSel = (state == IDLE) ? req_data : dataLat;
    drive   = (nextState == SETUP) || (nextState == WR_STB) || (nextState == HOLD);
  end

  // State, cycle counter, poll counter and request latches
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state   <= IDLE;
      cnt     <= '0;
      pollCnt <= '0;
      rsLat   <= 1'b0;
      dataLat <= 8'h00;
    end else begin
      state   <= nextState;
      cnt     <= cntNext;
      pollCnt <= pollNext;
      if (accept) begin
        rsLat   <= req_rs;
        dataLat <= req_data;
      end
    end
  end

  // Registered bus and status outputs decoded from the next state
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      nCS         <= 1'b1;
      nWR         <= 1'b1;
      nRD         <= 1'b1;
      RS          <= 1'b0;
      DB_oe       <= 1'b0;
      DB_out      <= 8'h00;
      req_ready   <= 1'b0;
      done        <= 1'b0;
      busy_to     <= 1'b0;
      last_status <= 8'h00;
    end else begin
      nCS         <= !((nextState == RD_STB) || (nextState == WR_STB));
      nWR         <= !(nextState == WR_STB);
      nRD         <= !(nextState == RD_STB);
      RS          <= drive & rsSel;
      DB_oe       <= drive;
      if (drive) begin
        DB_out <= dataSel;
      end
      req_ready   <= (nextState == IDLE);
      done        <= doneNext;
      busy_to     <= busyToNext;
      last_status <= statusNext;
    end
  end

endmodule
